// File: rtl/out_buf_pkg.sv
// ----------------------------------------------------------------------------
// out_buf_pkg
// Shared definitions for the output sample buffer:
//   - sample width and saturation limits (two's complement)
//   - FSM state encoding
//   - sat_shl(): arithmetic left shift with saturation to the sample range
// ----------------------------------------------------------------------------
package out_buf_pkg;

    localparam int SAMPLE_W = 16;

    // Headroom for the largest shift (gain_shift is 3 bits, max 7).
    localparam int EXT_W = SAMPLE_W + 8;

    localparam int SAMPLE_MAX_I = (2 ** (SAMPLE_W - 1)) - 1;
    localparam int SAMPLE_MIN_I = -(2 ** (SAMPLE_W - 1));

    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = SAMPLE_W'(SAMPLE_MAX_I);
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = SAMPLE_W'(SAMPLE_MIN_I);

    localparam logic signed [EXT_W-1:0] EXT_MAX = EXT_W'(SAMPLE_MAX_I);
    localparam logic signed [EXT_W-1:0] EXT_MIN = EXT_W'(SAMPLE_MIN_I);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    // Shift into a wide signed word, then clamp back to the sample range.
    function automatic logic [SAMPLE_W-1:0] sat_shl(
        input logic signed [SAMPLE_W-1:0] sample,
        input logic        [2:0]          shift
    );
        logic signed [EXT_W-1:0] ext;
        ext = {{(EXT_W - SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
        ext = ext <<< shift;
        if (ext > EXT_MAX) begin
            return SAMPLE_MAX;
        end else if (ext < EXT_MIN) begin
            return SAMPLE_MIN;
        end else begin
            return ext[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/out_sample_buffer_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a register array, wrapping read/write pointers and
// an occupancy counter one bit wider than the pointers (full vs. empty).
// Head data is presented combinationally from the read pointer.
//
// Ports
//   clk_i     clock
//   rst_i     synchronous reset, active-high
//   flush_i   synchronous flush, empties the FIFO (wins over push/pop)
//   push_i    write din_i (ignored when full unless a pop happens too)
//   pop_i     remove head (ignored when empty)
//   din_i     write data
//   dout_o    head entry
//   level_o   occupancy 0..DEPTH
//   full_o    level_o == DEPTH
//   empty_o   level_o == 0
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW + 1)'(DEPTH));
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // A simultaneous pop frees a slot, so a full FIFO can still take a push.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                level_d = level_q + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                level_d = level_q - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/out_sample_buffer.sv
// ----------------------------------------------------------------------------
// out_sample_buffer
// Elastic buffer between the ANC filter output (single-cycle valid pulse, no
// backpressure) and the I2S DAC transmitter (valid/ready pull).
//   - registered gain stage: sample <<< gain_shift, saturated
//   - FIFO prefill before playback (IDLE -> PREFILL -> RUN)
//   - underrun repeats the last played sample and returns to PREFILL
//   - sticky overflow/underrun flags, cleared by clr_flags (a new event wins)
//
// Optional build macro
//   OUT_BUF_STATS_EN  adds saturating 16-bit event counters ovf_cnt/unf_cnt,
//                     cleared by rst or clr_flags
//
// Ports
//   clk         clock
//   rst         synchronous reset, active-high
//   en          0 = flush and idle, 1 = operate
//   gain_shift  left-shift amount 0..7, sampled with in_valid
//   in_sample   filter output sample
//   in_valid    single-cycle pulse, always accepted
//   out_sample  sample offered to the transmitter
//   out_vld     out_sample valid (RUN state)
//   out_rdy     transmitter takes the sample when out_vld & out_rdy
//   level       FIFO occupancy
//   overflow    sticky: a write was dropped because the FIFO was full
//   underrun    sticky: a handshake occurred while the FIFO was empty
//   ovf_cnt     (OUT_BUF_STATS_EN) overflow event count
//   unf_cnt     (OUT_BUF_STATS_EN) underrun event count
//   clr_flags   clears the sticky flags and counters
// ----------------------------------------------------------------------------
module out_sample_buffer
    import out_buf_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PREFILL  = 4,
    parameter int SAMPLE_W = out_buf_pkg::SAMPLE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [2:0]               gain_shift,
    input  logic [SAMPLE_W-1:0]      in_sample,
    input  logic                     in_valid,
    output logic [SAMPLE_W-1:0]      out_sample,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underrun,
`ifdef OUT_BUF_STATS_EN
    output logic [15:0]              ovf_cnt,
    output logic [15:0]              unf_cnt,
`endif
    input  logic                     clr_flags
);

    localparam int LW = $clog2(DEPTH) + 1;

    // Gain stage
    logic                g_vld_q,  g_vld_d;
    logic [SAMPLE_W-1:0] g_data_q, g_data_d;

    // FIFO interface
    logic                fifo_push;
    logic                fifo_pop;
    logic [SAMPLE_W-1:0] fifo_dout;
    logic [LW-1:0]       fifo_level;
    logic                fifo_full;
    logic                fifo_empty;

    // Control
    state_e              state_q;
    logic                vld_q;
    logic                in_run;
    logic                hs;
    logic                hs_empty;
    logic                ovf_event;

    logic [SAMPLE_W-1:0] hold_q,     hold_d;
    logic                overflow_q, overflow_d;
    logic                underrun_q, underrun_d;

    // ------------------------------------------------------------------
    // Gain stage: one register stage, shift amount captured with the pulse.
    // ------------------------------------------------------------------
    always_comb begin
        g_vld_d  = en & in_valid;
        g_data_d = g_data_q;
        if (in_valid) begin
            g_data_d = sat_shl(in_sample, gain_shift);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_vld_q  <= 1'b0;
            g_data_q <= '0;
        end else begin
            g_vld_q  <= g_vld_d;
            g_data_q <= g_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Handshake / FIFO control
    // ------------------------------------------------------------------
    assign in_run    = (state_q == ST_RUN);
    assign hs        = in_run & out_rdy;
    assign fifo_pop  = hs & ~fifo_empty;
    assign hs_empty  = hs & fifo_empty;
    // A write into a full FIFO is only lost when no pop frees a slot.
    assign fifo_push = en & g_vld_q & (~fifo_full | fifo_pop);
    assign ovf_event = en & g_vld_q & fifo_full & ~fifo_pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (SAMPLE_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (~en),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (g_data_q),
        .dout_o  (fifo_dout),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------------------
    // FSM: out_vld is registered alongside the state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_q <= ST_PREFILL;
                    vld_q   <= 1'b0;
                end
                ST_PREFILL: begin
                    if (fifo_level >= LW'(PREFILL)) begin
                        state_q <= ST_RUN;
                        vld_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hs_empty) begin
                        state_q <= ST_PREFILL;
                        vld_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Hold register and sticky flags (both survive en=0)
    // ------------------------------------------------------------------
    always_comb begin
        hold_d     = fifo_pop ? fifo_dout : hold_q;
        overflow_d = ovf_event | (overflow_q & ~clr_flags);
        underrun_d = hs_empty  | (underrun_q & ~clr_flags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef OUT_BUF_STATS_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic [15:0] unf_cnt_q, unf_cnt_d;

    // On a clear coinciding with an event, the event is still counted.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        unf_cnt_d = unf_cnt_q;
        if (clr_flags) begin
            ovf_cnt_d = {15'd0, ovf_event};
            unf_cnt_d = {15'd0, hs_empty};
        end else begin
            if (ovf_event && ovf_cnt_q != 16'hFFFF) begin
                ovf_cnt_d = ovf_cnt_q + 16'd1;
            end
            if (hs_empty && unf_cnt_q != 16'hFFFF) begin
                unf_cnt_d = unf_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            unf_cnt_q <= unf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign unf_cnt = unf_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs: driven from registers only, never from out_rdy.
    // ------------------------------------------------------------------
    assign out_vld    = vld_q;
    assign out_sample = in_run ? (fifo_empty ? hold_q : fifo_dout) : '0;
    assign level      = fifo_level;
    assign overflow   = overflow_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_out_sample_buffer.sv
module tb_out_sample_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  gain_shift;
    logic [15:0] in_sample;
    logic        in_valid;
    logic [15:0] out_sample;
    logic        out_vld;
    logic        out_rdy;
    logic [3:0]  level;
    logic        overflow;
    logic        underrun;
    logic        clr_flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int in_val;
        int sh;
        int exp_val;
    } vec_t;

    vec_t tbl [8];

    out_sample_buffer #(
        .DEPTH    (8),
        .PREFILL  (4),
        .SAMPLE_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .gain_shift (gain_shift),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .out_sample (out_sample),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .level      (level),
        .overflow   (overflow),
        .underrun   (underrun),
        .clr_flags  (clr_flags)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int v, input int sh);
        in_sample  = 16'(v);
        gain_shift = 3'(sh);
        in_valid   = 1'b1;
        step(1);
        in_valid   = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        en         = 1'b0;
        in_valid   = 1'b0;
        in_sample  = '0;
        gain_shift = '0;
        out_rdy    = 1'b0;
        clr_flags  = 1'b0;
        step(2);
        rst        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1000,    3,   8000};
        tbl[1] = '{5000,    3,  32767};
        tbl[2] = '{-5000,   3, -32768};
        tbl[3] = '{100,     0,    100};
        tbl[4] = '{-1,      7,   -128};
        tbl[5] = '{16383,   1,  32766};
        tbl[6] = '{16384,   1,  32767};
        tbl[7] = '{-16384,  1, -32768};

        // ---------------- reset state ----------------
        @(negedge clk);
        do_reset();
        check("rst_level",    32'(level),    32'd0);
        check("rst_vld",      32'(out_vld),  32'd0);
        check("rst_sample",   sx(out_sample), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);

        // ---------------- prefill, playback, underrun ----------------
        en = 1'b1;
        out_rdy = 1'b1;
        pulse(100, 0);
        pulse(200, 0);
        pulse(300, 0);
        pulse(400, 0);
        step(1);
        check("t1_level4",    32'(level),   32'd4);
        check("t1_vld_low",   32'(out_vld), 32'd0);
        step(1);
        check("t1_vld_rise",  32'(out_vld), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t1_stream", sx(out_sample), 32'((i + 1) * 100));
            step(1);
        end
        check("t4_level0",    32'(level),    32'd0);
        check("t4_vld_empty", 32'(out_vld),  32'd1);
        check("t4_repeat",    sx(out_sample), 32'd400);
        check("t4_no_unf",    32'(underrun), 32'd0);
        step(1);
        out_rdy = 1'b0;
        check("t4_underrun",  32'(underrun), 32'd1);
        check("t4_vld_drop",  32'(out_vld),  32'd0);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        check("t4_unf_clr",   32'(underrun), 32'd0);

        // ---------------- gain table ----------------
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 8; i++) pulse(tbl[i].in_val, tbl[i].sh);
        step(2);
        check("t2_level8", 32'(level), 32'd8);
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_gain", sx(out_sample), 32'(tbl[i].exp_val));
            step(1);
        end
        out_rdy = 1'b0;
        check("t2_no_ovf", 32'(overflow), 32'd0);

        // ---------------- overflow and flag priority ----------------
        do_reset();
        en = 1'b1;
        for (int v = 1; v <= 9; v++) pulse(v, 0);
        step(2);
        check("t3_level8",   32'(level),    32'd8);
        check("t3_overflow", 32'(overflow), 32'd1);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        check("t3_ovf_clr",  32'(overflow), 32'd0);
        pulse(10, 0);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        check("t3_set_wins", 32'(overflow), 32'd1);
        check("t3_level_hold", 32'(level),  32'd8);
        out_rdy = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            check("t3_stream", sx(out_sample), 32'(v));
            step(1);
        end
        out_rdy = 1'b0;
        check("t3_level0",   32'(level),     32'd0);
        check("t3_no_ninth", sx(out_sample), 32'd8);
        check("t3_no_unf",   32'(underrun),  32'd0);

        // ---------------- write into full FIFO with simultaneous read ----------------
        do_reset();
        en = 1'b1;
        for (int v = 1; v <= 8; v++) pulse(v, 0);
        step(2);
        check("t5_level8", 32'(level),   32'd8);
        check("t5_vld",    32'(out_vld), 32'd1);
        pulse(50, 0);
        out_rdy = 1'b1;
        step(1);
        out_rdy = 1'b0;
        check("t5_level_stay", 32'(level),    32'd8);
        check("t5_no_ovf",     32'(overflow), 32'd0);
        out_rdy = 1'b1;
        for (int v = 2; v <= 9; v++) begin
            check("t5_stream", sx(out_sample), (v == 9) ? 32'd50 : 32'(v));
            step(1);
        end
        out_rdy = 1'b0;
        check("t5_drained", 32'(level), 32'd0);

        // ---------------- en dropped mid-operation, then refill ----------------
        do_reset();
        en = 1'b1;
        for (int v = 1; v <= 5; v++) pulse(v, 0);
        step(2);
        check("t6_level5", 32'(level),   32'd5);
        check("t6_vld",    32'(out_vld), 32'd1);
        en = 1'b0;
        step(1);
        check("t6_flush_level", 32'(level),   32'd0);
        check("t6_flush_vld",   32'(out_vld), 32'd0);
        en = 1'b1;
        pulse(11, 0);
        pulse(12, 0);
        pulse(13, 0);
        step(4);
        check("t6_level3",    32'(level),   32'd3);
        check("t6_still_idle", 32'(out_vld), 32'd0);
        pulse(14, 0);
        step(1);
        check("t6_level4",    32'(level),   32'd4);
        check("t6_vld_low",   32'(out_vld), 32'd0);
        step(1);
        check("t6_vld_high",  32'(out_vld), 32'd1);
        check("t6_first",     sx(out_sample), 32'd11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
